pcie_rx_detect_ctrl: RTL
========================

PCIE_RX_DETECT_CTRL -- requirements
Module: pcie_rx_detect_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk_i and rst_i as elsewhere in the codebase.
REQ-002 Parameters (name, default, meaning), which SHALL be:
- CLK_RATE, 100, clock frequency in MHz.
- MAX_NUM_LANES, 8, lane count (1..32).
- DETECT_TIMEOUT_US, 12, per-attempt timeout in microseconds.
- RETRY_WAIT_US, 12, quiet time between attempts in microseconds.
- MAX_RETRIES, 1, extra attempts after the first (0..7).
REQ-003 Ports (name, direction, width, meaning), which SHALL be:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- en_i, in, 1, block enable; low forces IDLE.
- start_i, in, 1, single-cycle pulse that starts detection.
- phy_phystatus_i, in, MAX_NUM_LANES, PIPE PhyStatus per lane.
- phy_rxstatus_i, in, 3*MAX_NUM_LANES, PIPE RxStatus; lane i is at [i*3+:3].
- phy_txdetectrx_o, out, 1, PIPE TxDetectRx request.
- lane_status_o, out, MAX_NUM_LANES, receiver-present mask.
- num_active_lanes_o, out, 6, count of lanes detected contiguously from lane 0.
- link_width_o, out, 6, negotiated width: 0, 1, 2, 4, 8, 16 or 32.
- busy_o, out, 1, detection in progress.
- done_o, out, 1, results valid.
- timeout_o, out, 1, set if the final attempt ended by timeout.

Function
REQ-004 The block SHALL use the states IDLE, DETECT, EVAL, WAIT and DONE.
REQ-005 The block SHALL derive TIMEOUT_CYCLES = CLK_RATE*DETECT_TIMEOUT_US and WAIT_CYCLES = CLK_RATE*RETRY_WAIT_US; one down-counter sized for the larger of the two SHALL serve both.
REQ-006 IDLE SHALL move to DETECT when en_i=1 and start_i=1, and SHALL clear lane_status_o, the attempt counter, timeout_o and done_o in that transition.
REQ-007 On entry to DETECT the block SHALL clear the seen mask and the detected mask and load TIMEOUT_CYCLES.
- phy_txdetectrx_o SHALL be a registered output, 1 on every cycle the state is DETECT and 0 otherwise.
REQ-008 In DETECT, whenever phy_phystatus_i[i]=1, the block SHALL set seen[i].
- It SHALL also set detected[i] if the lane's rxstatus equals 3'b011.
- Both bits are sticky within the attempt.
REQ-009 DETECT SHALL go to EVAL on the cycle after seen becomes all-ones, or when the counter reaches 0 (timeout).
- If both conditions occur in the same cycle, all-seen takes priority and the attempt is not a timeout.
REQ-010 EVAL SHALL last exactly one cycle.
- If detected is all-ones or attempt==MAX_RETRIES: go to DONE, and load lane_status_o from detected and timeout_o from the timeout flag of that attempt.
- Otherwise: increment the attempt counter, load WAIT_CYCLES and go to WAIT.
REQ-011 WAIT SHALL count down with phy_txdetectrx_o=0, and SHALL return to DETECT on the cycle after the counter reaches 0.
REQ-012 num_active_lanes_o SHALL equal the number of consecutive 1s in lane_status_o starting from bit 0.
- Example: a mask of 8'b1011_0111 gives 3.
REQ-013 link_width_o SHALL be the largest power of two that is less than or equal to num_active_lanes_o, or 0 when that count is 0.
- Example: a count of 3 gives 2.
REQ-014 Both num_active_lanes_o and link_width_o SHALL be registered and SHALL update on the same cycle as lane_status_o.
REQ-015 done_o SHALL be 1 exactly while in DONE.
- In DONE, start_i=1 SHALL restart detection (same transition as REQ-006).
REQ-016 busy_o SHALL be 1 exactly while in DETECT, EVAL or WAIT.
REQ-017 start_i asserted while busy_o=1 SHALL be ignored.
REQ-018 phy_phystatus_i and phy_rxstatus_i SHALL be ignored outside DETECT.
REQ-019 If en_i=0 in any state, the next state SHALL be IDLE.
- phy_txdetectrx_o, busy_o and done_o SHALL go to 0 on that next cycle.
- lane_status_o, num_active_lanes_o, link_width_o and timeout_o SHALL hold their values.

Reset
REQ-020 While rst_i=1 at the clock edge, the state SHALL become IDLE, all counters and masks SHALL become 0, and every output SHALL become 0.
REQ-021 Reset SHALL take priority over en_i and start_i, including when asserted in the middle of an attempt or a wait.

Structure
REQ-022 The state enum rx_detect_state_e and the localparam RXSTATUS_RX_PRESENT (3'b011) SHALL live in pcie_phy_pkg.
REQ-023 The contiguous-count and power-of-two logic SHALL be a separate combinational sub-module, pcie_lane_width_calc, parametrised by MAX_NUM_LANES.
REQ-024 The block SHALL replace the inline lane_status and num_active_lanes logic in the PHY top level.

Verification (CLK_RATE=100, DETECT_TIMEOUT_US=1 giving 100 cycles, RETRY_WAIT_US=1, MAX_NUM_LANES=8, MAX_RETRIES=1)
REQ-025 All 8 lanes pulse phystatus with rxstatus 011 on cycle 5 of DETECT:
- DONE after a single attempt.
- lane_status_o=8'hFF, num_active_lanes_o=8, link_width_o=8, timeout_o=0.
REQ-026 Lanes 0-2 and lane 5 report 011 and the other lanes report 000, on both attempts:
- Exactly one WAIT of 100 cycles with phy_txdetectrx_o=0.
- Final lane_status_o=8'h27, num_active_lanes_o=3, link_width_o=2.
REQ-027 Lane 7 never asserts phystatus and lanes 0-6 report 011:
- Each attempt times out after 100 cycles.
- Final lane_status_o=8'h7F, num_active_lanes_o=7, link_width_o=4, timeout_o=1.
REQ-028 The last lane's phystatus arrives on the same cycle the counter reaches 0:
- The attempt is treated as all-seen, with timeout_o=0.
REQ-029 en_i is dropped in WAIT, then start_i is pulsed while busy:
- IDLE on the next cycle, phy_txdetectrx_o=0.
- The start_i pulse while busy changes nothing.
REQ-030 rst_i is asserted in the middle of DETECT:
- All outputs are 0 on the next cycle.
- A later start_i begins a fresh attempt with the attempt counter at 0.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared PHY-layer types and constants for the PCIe PIPE receiver-detect logic.
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DETECT = 3'd1,
        EVAL   = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } rx_detect_state_e;

    // PIPE RxStatus encoding reported during TxDetectRx when a receiver is present.
    localparam logic [2:0] RXSTATUS_RX_PRESENT = 3'b011;

endpackage

// File: rtl/pcie_rx_detect_ctrl_if.sv
// Bundle of the receiver-detect control and PIPE sideband signals, with
// master (controller-side driver) and slave (detect block) views.
interface pcie_rx_detect_ctrl_if #(
    parameter int MAX_NUM_LANES = 8
);
    // start is a single-cycle request accepted only when the block is not busy;
    // done stays high from completion until the next accepted start or en drop.
    logic                         en;
    logic                         start;
    logic [MAX_NUM_LANES-1:0]     phystatus;
    logic [3*MAX_NUM_LANES-1:0]   rxstatus;
    logic                         txdetectrx;
    logic [MAX_NUM_LANES-1:0]     lane_status;
    logic [5:0]                   num_active_lanes;
    logic [5:0]                   link_width;
    logic                         busy;
    logic                         done;
    logic                         timeout;

    modport master (
        output en, start, phystatus, rxstatus,
        input  txdetectrx, lane_status, num_active_lanes, link_width, busy, done, timeout
    );

    modport slave (
        input  en, start, phystatus, rxstatus,
        output txdetectrx, lane_status, num_active_lanes, link_width, busy, done, timeout
    );

endinterface

// File: rtl/pcie_lane_width_calc.sv
// Counts consecutive present lanes from lane 0 and rounds the count down to a
// legal PCIe link width (power of two, or 0).
module pcie_lane_width_calc #(
    parameter int MAX_NUM_LANES = 8
) (
    input  logic [MAX_NUM_LANES-1:0] lane_mask_i,
    output logic [5:0]               num_active_lanes_o,
    output logic [5:0]               link_width_o
);

    logic run;

    always_comb begin
        num_active_lanes_o = '0;
        run = 1'b1;
        for (int i = 0; i < MAX_NUM_LANES; i++) begin
            run = run & lane_mask_i[i];
            if (run) begin
                num_active_lanes_o = num_active_lanes_o + 6'd1;
            end
        end
    end

    always_comb begin
        link_width_o = '0;
        for (int k = 0; k < 6; k++) begin
            if (num_active_lanes_o >= (6'd1 << k)) begin
                link_width_o = 6'd1 << k;
            end
        end
    end

endmodule

// File: rtl/pcie_rx_detect_ctrl.sv
// Receiver-detect sequencer: pulses PIPE TxDetectRx, collects per-lane results,
// retries after a quiet period, and reports the lane mask and link width.
module pcie_rx_detect_ctrl
    import pcie_phy_pkg::*;
#(
    parameter int CLK_RATE          = 100,
    parameter int MAX_NUM_LANES     = 8,
    parameter int DETECT_TIMEOUT_US = 12,
    parameter int RETRY_WAIT_US     = 12,
    parameter int MAX_RETRIES       = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         start_i,
    input  logic [MAX_NUM_LANES-1:0]     phy_phystatus_i,
    input  logic [3*MAX_NUM_LANES-1:0]   phy_rxstatus_i,
    output logic                         phy_txdetectrx_o,
    output logic [MAX_NUM_LANES-1:0]     lane_status_o,
    output logic [5:0]                   num_active_lanes_o,
    output logic [5:0]                   link_width_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         timeout_o
);

    localparam int TIMEOUT_CYCLES = CLK_RATE * DETECT_TIMEOUT_US;
    localparam int WAIT_CYCLES    = CLK_RATE * RETRY_WAIT_US;
    localparam int MAX_CYCLES     = (TIMEOUT_CYCLES > WAIT_CYCLES) ? TIMEOUT_CYCLES : WAIT_CYCLES;
    localparam int CNT_W          = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0]         TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]         WAIT_LOAD    = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]         CNT_ONE      = CNT_W'(1);
    localparam logic [2:0]               LAST_ATTEMPT = 3'(MAX_RETRIES);
    localparam logic [MAX_NUM_LANES-1:0] ALL_LANES    = '1;

    rx_detect_state_e           state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [2:0]                 attempt_q, attempt_d;
    logic [MAX_NUM_LANES-1:0]   seen_q, seen_d;
    logic [MAX_NUM_LANES-1:0]   det_q, det_d;
    logic                       to_flag_q, to_flag_d;
    logic                       txdet_q, txdet_d;
    logic [MAX_NUM_LANES-1:0]   lane_status_q, lane_status_d;
    logic [5:0]                 num_q, num_d;
    logic [5:0]                 width_q, width_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       timeout_q, timeout_d;

    logic [MAX_NUM_LANES-1:0]   rx_present;
    logic [MAX_NUM_LANES-1:0]   seen_next;
    logic [MAX_NUM_LANES-1:0]   det_next;
    logic [CNT_W-1:0]           cnt_dec;
    logic                       cnt_expiring;
    logic [5:0]                 calc_num;
    logic [5:0]                 calc_width;

    always_comb begin
        rx_present = '0;
        for (int i = 0; i < MAX_NUM_LANES; i++) begin
            rx_present[i] = (phy_rxstatus_i[i*3 +: 3] == RXSTATUS_RX_PRESENT);
        end
    end

    pcie_lane_width_calc #(
        .MAX_NUM_LANES (MAX_NUM_LANES)
    ) u_width_calc (
        .lane_mask_i        (det_q),
        .num_active_lanes_o (calc_num),
        .link_width_o       (calc_width)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        attempt_d     = attempt_q;
        seen_d        = seen_q;
        det_d         = det_q;
        to_flag_d     = to_flag_q;
        lane_status_d = lane_status_q;
        num_d         = num_q;
        width_d       = width_q;
        timeout_d     = timeout_q;

        seen_next    = seen_q | phy_phystatus_i;
        det_next     = det_q | (phy_phystatus_i & rx_present);
        cnt_dec      = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;
        // The count "reaches 0" on the cycle whose decrement lands on 0.
        cnt_expiring = (cnt_q <= CNT_ONE);

        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_d       = DETECT;
                        lane_status_d = '0;
                        num_d         = '0;
                        width_d       = '0;
                        attempt_d     = '0;
                        timeout_d     = 1'b0;
                        seen_d        = '0;
                        det_d         = '0;
                        to_flag_d     = 1'b0;
                        cnt_d         = TIMEOUT_LOAD;
                    end
                end
                DETECT: begin
                    seen_d = seen_next;
                    det_d  = det_next;
                    cnt_d  = cnt_dec;
                    // All-seen wins over a simultaneous timeout.
                    if (seen_next == ALL_LANES) begin
                        state_d   = EVAL;
                        to_flag_d = 1'b0;
                    end else if (cnt_expiring) begin
                        state_d   = EVAL;
                        to_flag_d = 1'b1;
                    end
                end
                EVAL: begin
                    if ((det_q == ALL_LANES) || (attempt_q == LAST_ATTEMPT)) begin
                        state_d       = DONE;
                        lane_status_d = det_q;
                        num_d         = calc_num;
                        width_d       = calc_width;
                        timeout_d     = to_flag_q;
                    end else begin
                        state_d   = WAIT;
                        attempt_d = attempt_q + 3'd1;
                        cnt_d     = WAIT_LOAD;
                    end
                end
                WAIT: begin
                    cnt_d = cnt_dec;
                    if (cnt_expiring) begin
                        state_d   = DETECT;
                        seen_d    = '0;
                        det_d     = '0;
                        to_flag_d = 1'b0;
                        cnt_d     = TIMEOUT_LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        txdet_d = (state_d == DETECT);
        busy_d  = (state_d == DETECT) || (state_d == EVAL) || (state_d == WAIT);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            attempt_q     <= '0;
            seen_q        <= '0;
            det_q         <= '0;
            to_flag_q     <= 1'b0;
            txdet_q       <= 1'b0;
            lane_status_q <= '0;
            num_q         <= '0;
            width_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            attempt_q     <= attempt_d;
            seen_q        <= seen_d;
            det_q         <= det_d;
            to_flag_q     <= to_flag_d;
            txdet_q       <= txdet_d;
            lane_status_q <= lane_status_d;
            num_q         <= num_d;
            width_q       <= width_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end

    assign phy_txdetectrx_o   = txdet_q;
    assign lane_status_o      = lane_status_q;
    assign num_active_lanes_o = num_q;
    assign link_width_o       = width_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign timeout_o          = timeout_q;

endmodule
